// File: rtl/pcm_sample_mixer_if.sv
// Valid/ready stream carrying mixed signed PCM samples from the mixer to the codec sink.
interface pcm_sample_mixer_if #(
  parameter int unsigned OUT_W = 16
);
  logic signed [OUT_W-1:0] pcm_data;
  logic                    pcm_valid;
  logic                    pcm_ready;

  modport master (output pcm_data, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pcm_sample_mixer.sv
// Multi-channel PCM output stage: fractional sample-rate tick, snapshot, sequential gain/mix MAC,
// saturation and a first-word-fall-through output FIFO.
module pcm_sample_mixer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned IN_W       = 8,
  parameter int unsigned GAIN_W     = 4,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned OUT_SHIFT  = 2,
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned PHASE_INC  = 13107,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                         masterclk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CH*IN_W-1:0]       ch_data,
  input  logic [NUM_CH-1:0]            ch_mute,
  input  logic [NUM_CH*GAIN_W-1:0]     ch_gain,
  pcm_sample_mixer_if.master           pcm,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [7:0]                   drop_cnt
);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned ACC_W = IN_W + GAIN_W + $clog2(NUM_CH) + 2;
  localparam int unsigned SH_W  = ACC_W + OUT_SHIFT;
  localparam int unsigned CMP_W = ((SH_W > OUT_W) ? SH_W : OUT_W) + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StWrite} state_e;

  // Sample-rate tick: carry-out of the phase accumulator.
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W:0]   phase_sum;
  logic               tick_q;

  assign phase_sum = {1'b0, phase_q} + (PHASE_W+1)'(PHASE_INC);

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else if (en) begin
      phase_q <= phase_sum[PHASE_W-1:0];
      tick_q  <= phase_sum[PHASE_W];
    end else begin
      tick_q  <= 1'b0;
    end
  end

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_CH*IN_W-1:0]    data_q, data_d;
  logic [NUM_CH-1:0]         mute_q, mute_d;
  logic [NUM_CH*GAIN_W-1:0]  gain_q, gain_d;
  logic                      push_req, tick_drop;

  // Offset-binary to two's complement is an MSB flip.
  logic [IN_W-1:0]           cur_data;
  logic [GAIN_W-1:0]         cur_gain;
  logic signed [IN_W-1:0]    cur_s;
  logic signed [ACC_W-1:0]   s_ext, g_ext, term;

  assign cur_data = data_q[idx_q*IN_W +: IN_W];
  assign cur_gain = gain_q[idx_q*GAIN_W +: GAIN_W];
  assign cur_s    = {~cur_data[IN_W-1], cur_data[IN_W-2:0]};
  assign s_ext    = ACC_W'(cur_s);
  assign g_ext    = ACC_W'({1'b0, cur_gain});
  assign term     = mute_q[idx_q] ? '0 : s_ext * g_ext;

  logic signed [CMP_W-1:0] wide;
  logic signed [OUT_W-1:0] sat;

  assign wide = CMP_W'(acc_q) <<< OUT_SHIFT;

  always_comb begin
    sat = wide[OUT_W-1:0];
    if (wide > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (wide < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    data_d   = data_q;
    mute_d   = mute_q;
    gain_d   = gain_q;
    push_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick_q) begin
          data_d  = ch_data;
          mute_d  = ch_mute;
          gain_d  = ch_gain;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_q + term;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        push_req = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    tick_drop = tick_q && (state_q != StIdle);
  end

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      mute_q  <= '0;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      mute_q  <= mute_d;
      gain_q  <= gain_d;
    end
  end

  logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q;
  logic signed [OUT_W-1:0] last_q;
  logic                    fifo_full, pop, push, full_drop;
  logic [7:0]              drop_q, drop_d;
  logic [9:0]              drop_sum;

  assign pcm.pcm_valid = (level_q != '0);
  assign fifo_full     = (level_q == FULL_LVL);
  assign pop           = pcm.pcm_valid & pcm.pcm_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push          = push_req & (~fifo_full | pop);
  assign full_drop     = push_req & ~push;
  // last_q keeps the output stable (and defined) while the FIFO is empty.
  assign pcm.pcm_data  = pcm.pcm_valid ? mem_q[rd_ptr_q] : last_q;
  assign fifo_level    = level_q;
  assign drop_cnt      = drop_q;

  assign drop_sum = {2'b00, drop_q} + {9'd0, tick_drop} + {9'd0, full_drop};
  assign drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
      drop_q   <= '0;
    end else begin
      drop_q <= drop_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge masterclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sat;
    end
  end
endmodule
